fetch_queue_unit: RTL and testbench

//  Parametrised instruction-fetch stage. Owns a DEPTH-entry instruction memory; each

---
 rtl/fetch_queue_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: cleared bundle memory, program-load port, in-order fetch queue.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_queue_unit #(
    parameter int unsigned             INSTR_W   = 30,
    parameter int unsigned             ISSUE_W   = 2,
    parameter int unsigned             DEPTH     = 256,
    parameter int unsigned             ADDR_W    = 16,
    parameter int unsigned             FQ_DEPTH  = 4,
    parameter logic [INSTR_W-1:0]      NOP_INSTR = 30'h2000_0000
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic [ADDR_W-1:0]           pc_i,
    input  logic                        pc_valid_i,
    output logic                        pc_ready_o,
    input  logic                        flush_i,
    input  logic                        wr_en_i,
    input  logic [ADDR_W-1:0]           wr_addr_i,
    input  logic [ISSUE_W*INSTR_W-1:0]  wr_data_i,
    output logic [ISSUE_W*INSTR_W-1:0]  data_o,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        fault_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        busy_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                 fetch_count_o,
    output logic [31:0]                 stall_count_o
`endif
);

    localparam int unsigned BW = ISSUE_W * INSTR_W;
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [BW-1:0]     NOP_BUNDLE = {ISSUE_W{NOP_INSTR}};
    localparam logic [ADDR_W:0]   DEPTH_LIM  = (ADDR_W+1)'(DEPTH);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     clr_q, clr_d;
    logic              run;

    logic [BW-1:0]     mem [DEPTH];

    logic [BW-1:0]     fq_data_q  [FQ_DEPTH];
    logic [ADDR_W-1:0] fq_pc_q    [FQ_DEPTH];
    logic              fq_fault_q [FQ_DEPTH];

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pc_ready_q, pc_ready_d;

    logic              push, pop;
    logic              pc_in_range, wr_in_range;
    logic [BW-1:0]     fetch_bundle;

    // FSM: state register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_q == IW'(DEPTH - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run    = (state_q == RUN);
        busy_o = (state_q == CLEAR);
        clr_d  = run ? '0 : clr_q + 1'b1;
    end

    assign pc_in_range  = {1'b0, pc_i} < DEPTH_LIM;
    assign wr_in_range  = {1'b0, wr_addr_i} < DEPTH_LIM;
    // Combinational read ahead of the write edge gives read-before-write ordering.
    assign fetch_bundle = pc_in_range ? mem[pc_i[IW-1:0]] : NOP_BUNDLE;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (!run)
                mem[clr_q] <= NOP_BUNDLE;
            else if (wr_en_i && wr_in_range)
                mem[wr_addr_i[IW-1:0]] <= wr_data_i;
        end
    end

    assign valid_o    = (cnt_q != '0);
    assign pop        = valid_o && ready_i;
    assign push       = run && pc_valid_i && pc_ready_q;
    assign pc_ready_o = pc_ready_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (run && flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
        // Ready is registered from next occupancy, so a full queue never takes a push.
        pc_ready_d = (state_d == RUN) && (cnt_d < CW'(FQ_DEPTH));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            pc_ready_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            pc_ready_q <= pc_ready_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i && push && !flush_i) begin
            fq_data_q[tail_q]  <= fetch_bundle;
            fq_pc_q[tail_q]    <= pc_i;
            fq_fault_q[tail_q] <= !pc_in_range;
        end
    end

    assign data_o  = valid_o ? fq_data_q[head_q]  : '0;
    assign pc_o    = valid_o ? fq_pc_q[head_q]    : '0;
    assign fault_o = valid_o ? fq_fault_q[head_q] : 1'b0;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push && fetch_cnt_q != '1)
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            if (run && pc_valid_i && !pc_ready_q && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed self-checking bench for fetch_queue_unit (default build, 256 x 2x30-bit bundles).
module tb_fetch_queue_unit;

    localparam logic [59:0] NOP = {2{30'h2000_0000}};
    localparam logic [59:0] W2  = 60'h0_0010_8020_0000_00;
    localparam logic [59:0] WX  = 60'hABC_DEF0_1234_5678;
    localparam logic [59:0] WY  = 60'h123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        reset_i, pc_valid_i, pc_ready_o, flush_i, wr_en_i;
    logic        fault_o, valid_o, ready_i, busy_o;
    logic [15:0] pc_i, wr_addr_i, pc_o;
    logic [59:0] wr_data_i, data_o;

    int checks = 0;
    int passed = 0;

    fetch_queue_unit dut (
        .clock_i    (clk),
        .reset_i    (reset_i),
        .pc_i       (pc_i),
        .pc_valid_i (pc_valid_i),
        .pc_ready_o (pc_ready_o),
        .flush_i    (flush_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .data_o     (data_o),
        .pc_o       (pc_o),
        .fault_o    (fault_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] pc);
        pc_i       = pc;
        pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
    endtask

    task automatic pop_one;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        reset_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({valid_o, fault_o, pc_ready_o, busy_o} !== 4'b0001 || data_o !== '0 || pc_o !== '0)
            $display("FAIL reset_state: valid=%b fault=%b rdy=%b busy=%b data=%h pc=%h, required 0 0 0 1 0 0",
                     valid_o, fault_o, pc_ready_o, busy_o, data_o, pc_o);
        else passed++;
        reset_i = 1'b0;
        repeat (10) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        n = 0;
        while (busy_o && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 256) $display("FAIL busy_cycles: got %0d, required 256", n);
        else passed++;
        checks++;
        if (pc_ready_o !== 1'b1 || valid_o !== 1'b0)
            $display("FAIL run_entry: rdy=%b valid=%b, required 1 0", pc_ready_o, valid_o);
        else passed++;
    endtask

    task automatic test_basic_fetch;
        fetch(16'd4);
        checks++;
        if (valid_o !== 1'b1 || data_o !== NOP || pc_o !== 16'd4 || fault_o !== 1'b0)
            $display("FAIL fetch_pc4: valid=%b data=%h pc=%h fault=%b, required 1 %h 0004 0",
                     valid_o, data_o, pc_o, fault_o, NOP);
        else passed++;
        tick();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 16'd4)
            $display("FAIL hold_head: valid=%b pc=%h, required 1 0004", valid_o, pc_o);
        else passed++;
        pop_one();
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || pc_o !== '0)
            $display("FAIL empty_after_pop: valid=%b data=%h pc=%h, required 0 0 0", valid_o, data_o, pc_o);
        else passed++;
    endtask

    task automatic test_write;
        wr_en_i = 1'b1; wr_addr_i = 16'd0; wr_data_i = W2;
        tick();
        wr_en_i = 1'b0;
        fetch(16'd0);
        checks++;
        if (data_o !== W2 || pc_o !== 16'd0)
            $display("FAIL write_read: data=%h pc=%h, required %h 0000", data_o, pc_o, W2);
        else passed++;
        pop_one();
    endtask

    task automatic test_backpressure;
        int exp_pc, next_req, n;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_ready_o !== 1'b1) $display("FAIL accept_%0d: rdy=%b, required 1", i, pc_ready_o);
            else passed++;
            fetch(16'(i));
        end
        pc_i = 16'd4; pc_valid_i = 1'b1;
        repeat (3) tick();
        checks++;
        if (pc_ready_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 16'd0)
            $display("FAIL full_stall: rdy=%b valid=%b pc=%h, required 0 1 0000", pc_ready_o, valid_o, pc_o);
        else passed++;
        ready_i  = 1'b1;
        exp_pc   = 0;
        next_req = 4;
        n        = 0;
        while (exp_pc < 6 && n < 30) begin
            if (valid_o) begin
                checks++;
                if (pc_o !== 16'(exp_pc)) $display("FAIL order: pc=%h, required %h", pc_o, 16'(exp_pc));
                else passed++;
                exp_pc++;
            end
            if (pc_valid_i && pc_ready_o) next_req++;
            tick();
            pc_i       = 16'(next_req);
            pc_valid_i = (next_req <= 5);
            n++;
        end
        pc_valid_i = 1'b0;
        ready_i    = 1'b0;
        checks++;
        if (exp_pc !== 6) $display("FAIL drain_count: delivered %0d, required 6", exp_pc);
        else passed++;
        tick();
        checks++;
        if (valid_o !== 1'b0) $display("FAIL drain_empty: valid=%b, required 0", valid_o);
        else passed++;
    endtask

    task automatic test_fault;
        fetch(16'h0100);
        checks++;
        if (fault_o !== 1'b1 || data_o !== NOP || pc_o !== 16'h0100)
            $display("FAIL oob_fault: fault=%b data=%h pc=%h, required 1 %h 0100", fault_o, data_o, pc_o, NOP);
        else passed++;
        pop_one();
        fetch(16'd1);
        checks++;
        if (fault_o !== 1'b0 || data_o !== NOP || pc_o !== 16'd1)
            $display("FAIL inrange_nofault: fault=%b data=%h pc=%h, required 0 %h 0001", fault_o, data_o, pc_o, NOP);
        else passed++;
        pop_one();
    endtask

    task automatic test_flush;
        ready_i = 1'b0;
        fetch(16'd1);
        fetch(16'd2);
        fetch(16'd3);
        pc_i = 16'd7; pc_valid_i = 1'b1; flush_i = 1'b1;
        tick();
        pc_valid_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || pc_ready_o !== 1'b1 || data_o !== '0)
            $display("FAIL flush: valid=%b rdy=%b data=%h, required 0 1 0", valid_o, pc_ready_o, data_o);
        else passed++;
        fetch(16'd9);
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 16'd9)
            $display("FAIL post_flush: valid=%b pc=%h, required 1 0009", valid_o, pc_o);
        else passed++;
        pop_one();
        checks++;
        if (valid_o !== 1'b0) $display("FAIL post_flush_only: valid=%b, required 0", valid_o);
        else passed++;
    endtask

    task automatic test_rbw;
        wr_en_i = 1'b1; wr_addr_i = 16'd3; wr_data_i = WX;
        fetch(16'd3);
        wr_en_i = 1'b0;
        checks++;
        if (data_o !== NOP) $display("FAIL rbw_old: data=%h, required %h", data_o, NOP);
        else passed++;
        pop_one();
        wr_en_i = 1'b1; wr_addr_i = 16'h0103; wr_data_i = WY;
        tick();
        wr_en_i = 1'b0;
        fetch(16'd3);
        checks++;
        if (data_o !== WX) $display("FAIL rbw_new: data=%h, required %h", data_o, WX);
        else passed++;
        pop_one();
    endtask

    initial begin
        reset_i = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; ready_i = 1'b0;
        #1;
        test_reset();
        test_basic_fetch();
        test_write();
        test_backpressure();
        test_fault();
        test_flush();
        test_rbw();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
